// File: rtl/maquina_maluca_monitor.sv
// maquina_maluca_monitor
// Passive checker for the state bus of maquina_maluca. It validates each
// sampled step against the coffee-cycle graph, counts finished cycles and
// reservoir refills, and latches the first protocol violation.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   state      in   [3:0] observed FSM state
//   busy       out  synced and observed state in 2..9
//   cycle_done out  one-clock pulse per 9->1 step
//   cups       out  [CW-1:0] completed cycles, saturating
//   refills    out  [CW-1:0] observed 3->4 steps, saturating
//   err        out  sticky violation flag
//   err_code   out  [1:0] 0 none, 1 illegal step, 2 out of range, 3 stall
//   err_from   out  [3:0] previous sample at the first violation
//   err_to     out  [3:0] offending sample at the first violation
module maquina_maluca_monitor #(
    parameter int CW        = 8,
    parameter int STALL_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    state,
    output logic          busy,
    output logic          cycle_done,
    output logic [CW-1:0] cups,
    output logic [CW-1:0] refills,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [3:0]    err_from,
    output logic [3:0]    err_to
);

    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        MON_UNSYNC = 2'd0,
        MON_SYNC   = 2'd1,
        MON_HALT   = 2'd2
    } mon_state_e;

    mon_state_e    mon_q, mon_d;
    logic [3:0]    s_q, s_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          busy_q, busy_d;
    logic          cycle_done_q, cycle_done_d;
    logic [CW-1:0] cups_q, cups_d;
    logic [CW-1:0] refills_q, refills_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [3:0]    err_from_q, err_from_d;
    logic [3:0]    err_to_q, err_to_d;
    logic          hold;

    function automatic logic in_range(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd9);
    endfunction

    function automatic logic in_work(input logic [3:0] v);
        return (v >= 4'd2) && (v <= 4'd9);
    endfunction

    // Self-holds are only reached here with an in-range value, because the
    // out-of-range check has priority.
    function automatic logic legal_step(input logic [3:0] f, input logic [3:0] t);
        logic ok;
        ok = (f == t);
        case ({f, t})
            8'h12, 8'h23, 8'h34, 8'h43, 8'h35,
            8'h56, 8'h67, 8'h78, 8'h89, 8'h91: ok = 1'b1;
            default: ;
        endcase
        return ok;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        mon_d        = mon_q;
        s_d          = state;
        stall_d      = '0;
        cycle_done_d = 1'b0;
        cups_d       = cups_q;
        refills_d    = refills_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        err_from_d   = err_from_q;
        err_to_d     = err_to_q;
        hold         = (state == s_q) && in_work(state);

        case (mon_q)
            MON_UNSYNC: begin
                if (state == 4'd1) mon_d = MON_SYNC;
            end
            MON_SYNC: begin
                if (!in_range(state)) begin
                    mon_d      = MON_HALT;
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    err_from_d = s_q;
                    err_to_d   = state;
                end else if (!legal_step(s_q, state)) begin
                    mon_d      = MON_HALT;
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    err_from_d = s_q;
                    err_to_d   = state;
                end else if (hold && (stall_q == SW'(STALL_MAX - 1))) begin
                    // This sample is the (STALL_MAX+1)-th of the same value.
                    mon_d      = MON_HALT;
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    err_from_d = s_q;
                    err_to_d   = state;
                end else begin
                    if (hold) stall_d = stall_q + SW'(1);
                    if ((s_q == 4'd9) && (state == 4'd1)) begin
                        cycle_done_d = 1'b1;
                        cups_d       = sat_inc(cups_q);
                    end
                    if ((s_q == 4'd3) && (state == 4'd4)) begin
                        refills_d = sat_inc(refills_q);
                    end
                end
            end
            default: ;
        endcase

        // busy keeps following the bus even after a halt.
        busy_d = (mon_d != MON_UNSYNC) && in_work(state);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mon_q        <= MON_UNSYNC;
            s_q          <= '0;
            stall_q      <= '0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            cups_q       <= '0;
            refills_q    <= '0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            err_from_q   <= '0;
            err_to_q     <= '0;
        end else begin
            mon_q        <= mon_d;
            s_q          <= s_d;
            stall_q      <= stall_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
            cups_q       <= cups_d;
            refills_q    <= refills_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_from_q   <= err_from_d;
            err_to_q     <= err_to_d;
        end
    end

    assign busy       = busy_q;
    assign cycle_done = cycle_done_q;
    assign cups       = cups_q;
    assign refills    = refills_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_from   = err_from_q;
    assign err_to     = err_to_q;

endmodule

// File: doc/maquina_maluca_monitor.md
# maquina_maluca_monitor

Passive observer on the `state[3:0]` bus driven by `maquina_maluca`. It checks every state-to-state step against the legal coffee-cycle graph and counts completed cycles and reservoir refills. It latches the first protocol violation for diagnosis. It sits beside the FSM in the top level and in benches, and never drives the FSM.

## Interface
- `CW`, default 8: width of the `cups` and `refills` counters.
- `STALL_MAX`, default 16: maximum consecutive edges a non-IDLE state may be held.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `state`  input  4  observed FSM state.
- `busy`  output  1  1 while the monitor is synced and the observed state is in 2..9.
- `cycle_done`  output  1  one-cycle pulse on each observed 9->1 step.
- `cups`  output  CW  completed cycles; saturates at 2^CW-1.
- `refills`  output  CW  observed 3->4 steps; saturates.
- `err`  output  1  sticky; set on the first violation.
- `err_code`  output  2  0 none, 1 illegal step, 2 out-of-range value, 3 stall timeout.
- `err_from`  output  4  previous sampled state at the first violation.
- `err_to`  output  4  offending state at the first violation.

## Operation
- State codes: 1 IDLE, 2 LIGAR_MAQUINA, 3 VERIFICAR_AGUA, 4 ENCHER_RESERVATORIO, 5 MOER_CAFE, 6 COLOCAR_NO_FILTRO, 7 PASSAR_AGITADOR, 8 TAMPEAR, 9 REALIZAR_EXTRACAO.
- Internal registers:
  - `s_q`: the state sampled at the previous edge.
  - `synced` flag.
  - stall counter.
- Monitor FSM:
  - UNSYNC (after reset): ignores all values; moves to SYNC on the first edge that samples `state==1`.
  - SYNC: evaluates the pair (`s_q`, `state`) every edge.
  - HALT: entered on the first error; `err`, `err_code`, `err_from`, `err_to`, `cups` and `refills` are frozen; `busy` keeps tracking `state`.
- Legal steps in SYNC:
  - Self-hold on any state 1..9.
  - 1->2, 2->3, 3->4, 4->3, 3->5, 5->6, 6->7, 7->8, 8->9, 9->1.
- Error checks, in priority order:
  1. Out-of-range: `state` equal to 0 or 10..15 while in SYNC gives code 2.
  2. Illegal step: any other non-legal step gives code 1.
  3. Stall: the stall counter reaches `STALL_MAX` gives code 3.
- Stall counter behaviour:
  - Increments when `state==s_q` and the value is in 2..9.
  - Clears on any change or when the state is IDLE. IDLE may hold indefinitely.
  - The counter width fits `STALL_MAX`.
- Counting:
  - 9->1 increments `cups` and pulses `cycle_done`.
  - 3->4 increments `refills`.
  - Both saturate. `cycle_done` still pulses when `cups` is saturated.
- Simultaneous events: an erroring edge never increments a counter and never pulses `cycle_done`.

## Timing
- Reset values: `busy`=0, `cycle_done`=0, `cups`=0, `refills`=0, `err`=0, `err_code`=0, `err_from`=0, `err_to`=0, `s_q`=0, stall counter=0, FSM in UNSYNC.
- Reset mid-operation (`rst_n` low at an edge) restores all reset values and returns the monitor to UNSYNC, regardless of `state`.
- All outputs are registered. When the FSM changes `state` at edge k, the monitor samples it at edge k+1, and outputs reflect the step after edge k+1. Latency is one clock.
- `cycle_done` is high for exactly one clock per 9->1 step.
- The stall error fires on the edge where the held value has been sampled `STALL_MAX`+1 consecutive times, i.e. after `STALL_MAX` holds.
- `err_code` and `err_from`/`err_to` change only from the reset value to the first error. Later errors are ignored until reset.

## Test plan
- Reset, then apply `state` sequence 0,1,1,2,3,4,3,5,6,7,8,9,1, one value per clock -> one `cycle_done` pulse one clock after 1 is sampled; `cups`=1, `refills`=1, `err`=0; `busy`=1 from the clock after 2 is sampled until the clock after the final 1 is sampled.
- Reset, then 1,2,3,5,7 -> `err`=1, `err_code`=1, `err_from`=5, `err_to`=7; `cups`/`refills` frozen at 0; further legal traffic leaves the error fields unchanged.
- Reset, then 1,2,3,5,6, with 6 held for 17 clocks (`STALL_MAX`=16) -> `err_code`=3, `err_from`=6, `err_to`=6, raised on the 17th sample; a 16-sample hold raises no error.
- Reset, then 1,2,12 -> `err_code`=2, `err_from`=2, `err_to`=12. Separately, 7,12,0,1 before sync -> no error and `busy`=0 until sync.
- With `CW`=2, run 5 full cycles -> `cups`=3 (saturated) and 5 `cycle_done` pulses. Separately, hold 1 for 100 clocks -> no stall error.
- Mid-cycle (state 6) assert `rst_n`=0 for one clock -> all outputs return to reset values; the monitor resyncs on the next 1.
